// File: rtl/alarm_bank_pkg.sv
// Shared definitions for the four-slot alarm bank: sizing constants, ring FSM states
// and the length-code to ring-seconds mapping.
package alarm_bank_pkg;

    localparam int N_ALARM  = 4;
    localparam int SEC_W    = 17;
    localparam int DAY_SECS = 86400;

    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } ring_state_t;

    function automatic logic [5:0] len_to_secs(input logic [1:0] code);
        case (code)
            2'd0:    len_to_secs = 6'd15;
            2'd1:    len_to_secs = 6'd30;
            2'd2:    len_to_secs = 6'd45;
            default: len_to_secs = 6'd60;
        endcase
    endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: validated configuration storage plus a combinational time match
// that always reflects the stored (pre-write) values.
module alarm_slot #(
    parameter int SEC_W    = alarm_bank_pkg::SEC_W,
    parameter int DAY_SECS = alarm_bank_pkg::DAY_SECS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             wr_enable,
    input  logic [SEC_W-1:0] wr_sec,
    input  logic [1:0]       wr_music,
    input  logic [1:0]       wr_len,
    input  logic [SEC_W-1:0] now_sec,
    output logic             reject,
    output logic             enable,
    output logic [SEC_W-1:0] sec,
    output logic [1:0]       music,
    output logic [1:0]       len,
    output logic             match
);

    logic bad_write;

    assign bad_write = (wr_sec >= SEC_W'(DAY_SECS)) || (wr_music == 2'd3);
    assign reject    = we && bad_write;
    assign match     = enable && (sec == now_sec);

    // A rejected write leaves every field untouched; an accepted one updates all four.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable <= 1'b0;
            sec    <= '0;
            music  <= '0;
            len    <= '0;
        end else if (we && !bad_write) begin
            enable <= wr_enable;
            sec    <= wr_sec;
            music  <= wr_music;
            len    <= wr_len;
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// Alarm register bank and ring controller: picks the lowest matching slot to ring,
// queues simultaneous matches as pending, and times each ring on the 1 Hz tick.
module alarm_bank #(
    parameter int N_ALARM  = alarm_bank_pkg::N_ALARM,
    parameter int SEC_W    = alarm_bank_pkg::SEC_W,
    parameter int DAY_SECS = alarm_bank_pkg::DAY_SECS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic [SEC_W-1:0] now_sec,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_idx,
    input  logic             cfg_enable,
    input  logic [SEC_W-1:0] cfg_sec,
    input  logic [1:0]       cfg_music,
    input  logic [1:0]       cfg_len,
    output logic             cfg_err,
    input  logic [1:0]       rd_idx,
    output logic             rd_enable,
    output logic [SEC_W-1:0] rd_sec,
    output logic [1:0]       rd_music,
    output logic [1:0]       rd_len,
    input  logic             dismiss,
    output logic             ring,
    output logic [1:0]       ring_idx,
    output logic [1:0]       ring_music,
    output logic [5:0]       ring_remain
);

    import alarm_bank_pkg::*;

    logic [N_ALARM-1:0] slot_en;
    logic [N_ALARM-1:0] slot_match;
    logic [N_ALARM-1:0] slot_rej;
    logic [SEC_W-1:0]   slot_sec   [N_ALARM];
    logic [1:0]         slot_music [N_ALARM];
    logic [1:0]         slot_len   [N_ALARM];

    ring_state_t        state, state_n;
    logic [N_ALARM-1:0] pending, pending_n;
    logic [N_ALARM-1:0] disable_mask;
    logic [N_ALARM-1:0] cand;
    logic [1:0]         ring_idx_n, ring_music_n, sel;
    logic [5:0]         ring_remain_n;
    logic               stop_ring;

    for (genvar g = 0; g < N_ALARM; g++) begin : g_slot
        alarm_slot #(
            .SEC_W    (SEC_W),
            .DAY_SECS (DAY_SECS)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .we        (cfg_we && (cfg_idx == 2'(g))),
            .wr_enable (cfg_enable),
            .wr_sec    (cfg_sec),
            .wr_music  (cfg_music),
            .wr_len    (cfg_len),
            .now_sec   (now_sec),
            .reject    (slot_rej[g]),
            .enable    (slot_en[g]),
            .sec       (slot_sec[g]),
            .music     (slot_music[g]),
            .len       (slot_len[g]),
            .match     (slot_match[g])
        );
    end

    function automatic logic [1:0] lowest(input logic [N_ALARM-1:0] v);
        lowest = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (v[i]) lowest = 2'(i);
        end
    endfunction

    function automatic logic [N_ALARM-1:0] onehot(input logic [1:0] i);
        onehot = N_ALARM'(1) << i;
    endfunction

    assign rd_enable = slot_en[rd_idx];
    assign rd_sec    = slot_sec[rd_idx];
    assign rd_music  = slot_music[rd_idx];
    assign rd_len    = slot_len[rd_idx];
    assign ring      = (state == RING);

    // An accepted write that turns a slot off cancels it both as pending and as ringer.
    assign disable_mask = (cfg_we && !(|slot_rej) && !cfg_enable) ? onehot(cfg_idx) : '0;

    always_comb begin
        state_n       = state;
        pending_n     = pending;
        ring_idx_n    = ring_idx;
        ring_music_n  = ring_music;
        ring_remain_n = ring_remain;
        cand          = '0;
        sel           = '0;
        stop_ring     = 1'b0;
        case (state)
            IDLE: begin
                if (tick_1hz) cand = slot_match & ~disable_mask;
                if (|cand) begin
                    sel           = lowest(cand);
                    state_n       = RING;
                    pending_n     = cand & ~onehot(sel);
                    ring_idx_n    = sel;
                    ring_music_n  = slot_music[sel];
                    ring_remain_n = len_to_secs(slot_len[sel]);
                end
            end
            RING: begin
                if (dismiss) begin
                    state_n       = IDLE;
                    pending_n     = '0;
                    ring_remain_n = '0;
                end else begin
                    cand = pending;
                    if (tick_1hz) begin
                        cand = cand | (slot_match & ~onehot(ring_idx));
                        if (ring_remain == 6'd1) stop_ring = 1'b1;
                        else ring_remain_n = ring_remain - 6'd1;
                    end
                    if ((disable_mask & onehot(ring_idx)) != '0) stop_ring = 1'b1;
                    cand      = cand & ~disable_mask;
                    pending_n = cand;
                    // Handover to the next pending slot happens on this same edge.
                    if (stop_ring) begin
                        if (|cand) begin
                            sel           = lowest(cand);
                            pending_n     = cand & ~onehot(sel);
                            ring_idx_n    = sel;
                            ring_music_n  = slot_music[sel];
                            ring_remain_n = len_to_secs(slot_len[sel]);
                        end else begin
                            state_n       = IDLE;
                            ring_remain_n = '0;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pending     <= '0;
            ring_idx    <= '0;
            ring_music  <= '0;
            ring_remain <= '0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_n;
            pending     <= pending_n;
            ring_idx    <= ring_idx_n;
            ring_music  <= ring_music_n;
            ring_remain <= ring_remain_n;
            cfg_err     <= |slot_rej;
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: directed stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_alarm_bank;

    localparam int SEC_W = 17;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tick_1hz = 1'b0;
    logic [SEC_W-1:0] now_sec = '0;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_idx = '0;
    logic             cfg_enable = 1'b0;
    logic [SEC_W-1:0] cfg_sec = '0;
    logic [1:0]       cfg_music = '0;
    logic [1:0]       cfg_len = '0;
    logic             cfg_err;
    logic [1:0]       rd_idx = '0;
    logic             rd_enable;
    logic [SEC_W-1:0] rd_sec;
    logic [1:0]       rd_music;
    logic [1:0]       rd_len;
    logic             dismiss = 1'b0;
    logic             ring;
    logic [1:0]       ring_idx;
    logic [1:0]       ring_music;
    logic [5:0]       ring_remain;

    alarm_bank #(
        .N_ALARM  (4),
        .SEC_W    (SEC_W),
        .DAY_SECS (86400)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .now_sec     (now_sec),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_enable  (cfg_enable),
        .cfg_sec     (cfg_sec),
        .cfg_music   (cfg_music),
        .cfg_len     (cfg_len),
        .cfg_err     (cfg_err),
        .rd_idx      (rd_idx),
        .rd_enable   (rd_enable),
        .rd_sec      (rd_sec),
        .rd_music    (rd_music),
        .rd_len      (rd_len),
        .dismiss     (dismiss),
        .ring        (ring),
        .ring_idx    (ring_idx),
        .ring_music  (ring_music),
        .ring_remain (ring_remain)
    );

    always #5 clk = ~clk;

    typedef enum int {CHK_RING_ON, CHK_RING_OFF, CHK_ALLZERO, CHK_ERR, CHK_RD} chk_kind_t;

    typedef struct {
        int          at_cyc;
        string       name;
        chk_kind_t   kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc++;

    // Monitor: every expectation due by this cycle is compared against the live outputs.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].at_cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.kind)
                CHK_RING_ON:  act = {21'b0, ring, ring_idx, ring_music, ring_remain};
                CHK_RING_OFF: act = {31'b0, ring};
                CHK_ALLZERO:  act = {20'b0, ring, ring_idx, ring_music, ring_remain, cfg_err};
                CHK_ERR:      act = {31'b0, cfg_err};
                default:      act = {10'b0, rd_enable, rd_sec, rd_music, rd_len};
            endcase
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("[TB] FAIL %s @cyc %0d: got %h, want %h", e.name, cyc, act, e.exp);
            end
        end
    end

    task automatic applyStimulus(input logic t, input logic [SEC_W-1:0] now, input logic dis,
                                 input logic we, input logic [1:0] idx, input logic en,
                                 input logic [SEC_W-1:0] sec, input logic [1:0] mus,
                                 input logic [1:0] len);
        @(posedge clk);
        #1;
        tick_1hz   = t;
        now_sec    = now;
        dismiss    = dis;
        cfg_we     = we;
        cfg_idx    = idx;
        cfg_enable = en;
        cfg_sec    = sec;
        cfg_music  = mus;
        cfg_len    = len;
    endtask

    task automatic checkOutput(input string name, input chk_kind_t kind, input logic [31:0] exp,
                               input int lead);
        exp_t e;
        e.at_cyc = cyc + lead;
        e.name   = name;
        e.kind   = kind;
        e.exp    = exp;
        sb_q.push_back(e);
    endtask

    task automatic do_idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0, '0, 2'd0, 2'd0);
    endtask

    task automatic do_tick(input logic [SEC_W-1:0] now);
        applyStimulus(1'b1, now, 1'b0, 1'b0, 2'd0, 1'b0, '0, 2'd0, 2'd0);
    endtask

    task automatic do_write(input logic [1:0] idx, input logic en, input logic [SEC_W-1:0] sec,
                            input logic [1:0] mus, input logic [1:0] len);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, idx, en, sec, mus, len);
    endtask

    task automatic do_read(input logic [1:0] idx);
        do_idle();
        rd_idx = idx;
    endtask

    task automatic expect_ring(input string name, input logic [1:0] idx, input logic [1:0] mus,
                               input logic [5:0] rem);
        checkOutput(name, CHK_RING_ON, {21'b0, 1'b1, idx, mus, rem}, 1);
    endtask

    task automatic expect_off(input string name);
        checkOutput(name, CHK_RING_OFF, 32'd0, 1);
    endtask

    task automatic expect_err(input string name, input logic v);
        checkOutput(name, CHK_ERR, {31'b0, v}, 1);
    endtask

    task automatic expect_rd(input string name, input logic en, input logic [SEC_W-1:0] sec,
                             input logic [1:0] mus, input logic [1:0] len);
        checkOutput(name, CHK_RD, {10'b0, en, sec, mus, len}, 1);
    endtask

    initial begin
        do_idle();
        checkOutput("reset_zero", CHK_ALLZERO, 32'd0, 1);
        do_idle();
        rst = 1'b1;
        do_read(1);
        expect_rd("reset_rd1", 1'b0, '0, 2'd0, 2'd0);

        // Single alarm, 15 s ring.
        do_write(2'd2, 1'b1, 17'd3600, 2'd1, 2'd0);
        expect_err("t1_wr_ok", 1'b0);
        do_read(2'd2);
        expect_rd("t1_rd", 1'b1, 17'd3600, 2'd1, 2'd0);
        do_tick(17'd3600);
        expect_ring("t1_start", 2'd2, 2'd1, 6'd15);
        for (int k = 1; k <= 14; k++) begin
            do_idle();
            do_tick(17'(3600 + k));
            expect_ring($sformatf("t1_tick%0d", k), 2'd2, 2'd1, 6'(15 - k));
        end
        do_idle();
        do_tick(17'd3615);
        expect_off("t1_end");

        // Rejected writes and a legal boundary write.
        do_write(2'd0, 1'b1, 17'd86400, 2'd0, 2'd0);
        expect_err("t2_err_sec", 1'b1);
        do_write(2'd1, 1'b1, 17'd10, 2'd3, 2'd0);
        expect_err("t2_err_music", 1'b1);
        do_read(2'd0);
        expect_err("t2_err_drop", 1'b0);
        expect_rd("t2_rd0", 1'b0, '0, 2'd0, 2'd0);
        do_read(2'd1);
        expect_rd("t2_rd1", 1'b0, '0, 2'd0, 2'd0);
        do_write(2'd3, 1'b0, 17'd86399, 2'd2, 2'd3);
        expect_err("t2_wr_max", 1'b0);
        do_read(2'd3);
        expect_rd("t2_rd3", 1'b0, 17'd86399, 2'd2, 2'd3);

        // Two slots match together: slot 1 first, slot 3 handed over with no gap.
        do_write(2'd1, 1'b1, 17'd100, 2'd2, 2'd0);
        do_write(2'd3, 1'b1, 17'd100, 2'd0, 2'd0);
        do_idle();
        do_tick(17'd100);
        expect_ring("t3_start1", 2'd1, 2'd2, 6'd15);
        for (int k = 1; k <= 14; k++) begin
            do_idle();
            do_tick(17'(100 + k));
            expect_ring($sformatf("t3_s1_tick%0d", k), 2'd1, 2'd2, 6'(15 - k));
        end
        do_idle();
        expect_ring("t3_s1_last", 2'd1, 2'd2, 6'd1);
        do_tick(17'd115);
        expect_ring("t3_handover", 2'd3, 2'd0, 6'd15);
        for (int k = 1; k <= 14; k++) begin
            do_idle();
            do_tick(17'(115 + k));
            expect_ring($sformatf("t3_s3_tick%0d", k), 2'd3, 2'd0, 6'(15 - k));
        end
        do_idle();
        do_tick(17'd130);
        expect_off("t3_end");

        // Dismiss coinciding with a tick that would re-match both slots.
        do_write(2'd0, 1'b1, 17'd200, 2'd1, 2'd1);
        do_write(2'd2, 1'b1, 17'd200, 2'd2, 2'd0);
        do_tick(17'd200);
        expect_ring("t4_start", 2'd0, 2'd1, 6'd30);
        do_tick(17'd201);
        expect_ring("t4_tick", 2'd0, 2'd1, 6'd29);
        applyStimulus(1'b1, 17'd200, 1'b1, 1'b0, 2'd0, 1'b0, '0, 2'd0, 2'd0);
        expect_off("t4_dismiss");
        for (int k = 3; k <= 40; k++) begin
            do_tick(17'(200 + k));
            if (k % 8 == 0) expect_off($sformatf("t4_quiet%0d", k));
        end
        do_idle();
        expect_off("t4_quiet_end");

        // Disabling the ringing slot hands over to the pending one.
        do_write(2'd1, 1'b1, 17'd300, 2'd2, 2'd0);
        do_write(2'd3, 1'b1, 17'd300, 2'd1, 2'd2);
        do_tick(17'd300);
        expect_ring("t5_start", 2'd1, 2'd2, 6'd15);
        do_tick(17'd301);
        expect_ring("t5_tick", 2'd1, 2'd2, 6'd14);
        do_write(2'd1, 1'b0, 17'd300, 2'd2, 2'd0);
        expect_ring("t5_disable", 2'd3, 2'd1, 6'd45);
        do_write(2'd3, 1'b1, 17'd300, 2'd0, 2'd2);
        expect_ring("t5_rewrite_keep", 2'd3, 2'd1, 6'd45);
        do_tick(17'd302);
        expect_ring("t5_tick2", 2'd3, 2'd1, 6'd44);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 2'd0, 1'b0, '0, 2'd0, 2'd0);
        expect_off("t5_dismiss");

        // Asynchronous reset in the middle of a 60 s ring.
        do_write(2'd0, 1'b1, 17'd400, 2'd0, 2'd3);
        do_tick(17'd400);
        expect_ring("t6_start", 2'd0, 2'd0, 6'd60);
        for (int k = 1; k <= 20; k++) begin
            do_tick(17'(400 + k));
        end
        expect_ring("t6_rem40", 2'd0, 2'd0, 6'd40);
        do_idle();
        do_idle();
        rst = 1'b0;
        checkOutput("t6_reset_zero", CHK_ALLZERO, 32'd0, 0);
        for (int i = 0; i < 4; i++) begin
            do_read(2'(i));
            expect_rd($sformatf("t6_rd%0d", i), 1'b0, '0, 2'd0, 2'd0);
        end
        do_tick(17'd400);
        checkOutput("t6_reset_hold", CHK_ALLZERO, 32'd0, 1);
        do_idle();
        rst = 1'b1;
        do_idle();

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            $display("[TB] FAIL drain: got %0d unchecked expectations, want 0", sb_q.size());
            miscompares += sb_q.size();
            vectors += sb_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_bank.md
# alarm_bank

Register bank and ring controller for the clock's four alarms. Consumes the running time-of-day seconds count and the 1 Hz tick. Holds per-alarm configuration written by the alarm-setting front end and decides which alarm is ringing and for how long. Drives the song player with a registered ring request, the selected tune and the remaining ring time.

## Interface
Parameters:
- N_ALARM, 4: number of alarm slots; index width is 2.
- SEC_W, 17: width of time-of-day seconds.
- DAY_SECS, 86400: seconds per day; legal times are 0..DAY_SECS-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-clk-wide pulse per second, synchronous to clk.
- now_sec  in  SEC_W  current time of day; stable around tick_1hz.
- cfg_we  in  1  one-cycle write strobe for slot cfg_idx.
- cfg_idx  in  2  slot to write.
- cfg_enable  in  1  alarm enable.
- cfg_sec  in  SEC_W  alarm time in seconds.
- cfg_music  in  2  tune 0..2.
- cfg_len  in  2  length code; ring length = 15*(code+1) s, giving 15/30/45/60.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- rd_idx  in  2  readback slot select.
- rd_enable, rd_sec, rd_music, rd_len  out  1/SEC_W/2/2  combinational readback of slot rd_idx.
- dismiss  in  1  one-cycle pulse that stops ringing.
- ring  out  1  alarm sounding.
- ring_idx  out  2  slot currently sounding.
- ring_music  out  2  tune of ringing slot.
- ring_remain  out  6  seconds left, 60..1 while ringing.

## Operation
- Reset clears all slots to enable=0, sec=0, music=0, len=0. It also clears pending bits and forces state to IDLE. Outputs reset to ring=0, ring_idx=0, ring_music=0, ring_remain=0 and cfg_err=0.
- Write rules:
  - A write with cfg_sec >= DAY_SECS or cfg_music == 3 leaves the slot unchanged and pulses cfg_err.
  - Otherwise all four fields are written together.
- Match: on tick_1hz, slot i matches when enable[i]=1 and sec[i]==now_sec. Pre-write slot values are used when cfg_we and tick_1hz coincide.
- IDLE: on tick_1hz with at least one match:
  - The lowest matching index starts ringing, and the state goes to RING.
  - ring_remain loads 15*(len+1) and ring_music loads that slot's music.
  - Other matching slots set their pending bits.
- RING:
  - Each tick_1hz decrements ring_remain.
  - A tick that arrives with ring_remain==1 ends the ring, so ring lasts exactly 15*(len+1) ticks.
  - New matches during RING set pending bits; a slot re-matching itself is ignored.
- Expiry: if any pending bit is set, the lowest pending slot starts ringing immediately, its pending bit clears, and the state stays RING. If none is pending, the state goes to IDLE.
- dismiss in RING goes to IDLE and clears all pending bits. dismiss in IDLE has no effect.
- Priority when dismiss and tick_1hz coincide: dismiss wins, and a match on that same tick is discarded.
- Writing cfg_enable=0 to a slot clears its pending bit. If that slot is ringing, the ring stops as on dismiss, but other pending bits are kept and served as on expiry.
- Rewriting the ringing slot with enable=1 keeps the current ring_remain and ring_music.

## Timing
- ring, ring_idx, ring_music and ring_remain are registered. They update on the clk edge that samples tick_1hz, dismiss or cfg_we: one-cycle latency.
- Slot storage updates on the clk edge that samples cfg_we. rd_* reflects the new value the following cycle.
- cfg_err is registered and high for exactly one cycle, aligned with the would-be update.
- Back-to-back writes are legal on every cycle.
- Handover between a finished ring and a pending one happens on the same edge, so ring stays high with no gap.
- Asynchronous reset mid-ring drops ring to 0 immediately.

## Structure
- Shared package holds:
  - DAY_SECS, N_ALARM and SEC_W;
  - the state enum {IDLE, RING};
  - a length-code-to-seconds function: 0→15, 1→30, 2→45, 3→60.
- One sub-module, alarm_slot, per slot. It holds the fields, applies write validation and produces a registered-independent match output.
- alarm_bank instantiates N_ALARM slots and contains the priority encoder, pending register and ring FSM.

## Test plan
- After reset, write slot 2 with en=1, sec=3600, music=1, len=0. Pulse a tick at now_sec=3600. Expect ring=1, ring_idx=2, ring_music=1 and ring_remain=15 one cycle later; ring falls after the 15th tick.
- Write slot 0 with sec=86400, then slot 1 with music=3. Expect a cfg_err pulse for each and rd_* unchanged at reset values.
- Slots 1 and 3 both match at 100, both with len=0. Expect slot 1 to ring for 15 ticks, then slot 3 to ring with ring_remain=15 on the same edge, with no gap in ring.
- Ringing slot 0 plus pending slot 2: pulse dismiss together with a tick. Expect ring=0 next cycle and no further ringing from slot 2.
- Ringing slot 1 plus pending slot 3: write slot 1 with en=0. Expect slot 3 to ring next cycle.
- Assert rst low mid-ring with ring_remain=40. Expect all outputs at zero while low, and every slot to read back en=0.
